// File: rtl/emd_pkg.sv
// ============================================================================
// Module   : emd_pkg
// Brief    : Shared types and widths for the EMD extremum/envelope chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package emd_pkg;

    localparam int EMD_DW = 16;
    localparam int EMD_TW = 16;

    // One detected extremum: the sample time index and its signed value.
    typedef struct packed {
        logic        [EMD_TW-1:0] tidx;
        logic signed [EMD_DW-1:0] val;
    } extremum_t;

endpackage

`default_nettype wire

// File: rtl/ei_fifo.sv
// ============================================================================
// Module   : ei_fifo
// Brief    : First-word-fall-through FIFO of extremum_t with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ei_fifo
    import emd_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  extremum_t              i_wdata,
    input  logic                   i_pop,
    output extremum_t              o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int              c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_full = DEPTH[c_aw:0];

    extremum_t       r_mem [DEPTH];
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw:0]   r_count;
    logic            w_push;
    logic            w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_full);
    assign o_count = r_count;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_pop  = i_pop & ~o_empty;
    assign w_push = i_push & (~o_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clr) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Empty reads as zero so the head outputs are clean after reset or flush.
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

`default_nettype wire

// File: rtl/ei_min_store.sv
// ============================================================================
// Module   : ei_min_store
// Brief    : Captures local-minimum (time, value) pairs into a FIFO, filters
//            repeated triggers and flags overflow. Optional build macro
//            MIN_SPACING_EN adds a minimum time-spacing filter (MIN_GAP).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ei_min_store
    import emd_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TW      = 16,
    parameter int DEPTH   = 16,
    parameter int MIN_GAP = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clr,
    input  logic                   i_trg,
    input  logic [TW-1:0]          i_time,
    input  logic [DW-1:0]          i_val,
    input  logic                   i_rd_ready,
    output logic                   o_rd_valid,
    output logic [TW-1:0]          o_rd_time,
    output logic [DW-1:0]          o_rd_val,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_ovf
);

    if (DW != EMD_DW || TW != EMD_TW || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0
        || MIN_GAP < 0) begin : g_param_check
        $error("ei_min_store: unsupported parameter set");
    end

    logic          r_ovf;
    logic          r_last_vld;
    logic [TW-1:0] r_last_time;
    logic          w_dup;
    logic          w_close;
    logic          w_cand;
    logic          w_pop;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    extremum_t     w_wdata;
    extremum_t     w_rdata;

    assign w_dup = r_last_vld && (i_time == r_last_time);

`ifdef MIN_SPACING_EN
    logic [TW-1:0] w_gap;
    assign w_gap   = i_time - r_last_time;
    assign w_close = r_last_vld && (w_gap < TW'(MIN_GAP));
`else
    assign w_close = 1'b0;
`endif

    // CLR beats a same-cycle trigger; filtered triggers never touch OVF.
    assign w_cand  = i_trg && !i_clr && !w_dup && !w_close;
    assign w_pop   = !w_empty && i_rd_ready;
    assign w_push  = w_cand && (!w_full || w_pop);

    assign w_wdata.tidx = i_time;
    assign w_wdata.val  = i_val;

    ei_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (i_clr),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_count (o_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf       <= 1'b0;
            r_last_vld  <= 1'b0;
            r_last_time <= '0;
        end else if (i_clr) begin
            r_ovf       <= 1'b0;
            r_last_vld  <= 1'b0;
        end else begin
            if (w_cand && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_last_vld  <= 1'b1;
                r_last_time <= i_time;
            end
        end
    end

    assign o_rd_valid = !w_empty;
    assign o_rd_time  = w_rdata.tidx;
    assign o_rd_val   = w_rdata.val;
    assign o_ovf      = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ei_min_store.sv
// ============================================================================
// Module   : tb_ei_min_store
// Brief    : Scoreboard bench for ei_min_store (honours MIN_SPACING_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ei_min_store;
    import emd_pkg::*;

    localparam int DEPTH   = 16;
    localparam int MIN_GAP = 2;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               clr      = 1'b0;
    logic               trg      = 1'b0;
    logic        [15:0] tim      = '0;
    logic signed [15:0] val      = '0;
    logic               rd_ready = 1'b0;
    logic               rd_valid;
    logic        [15:0] rd_time;
    logic signed [15:0] rd_val;
    logic         [4:0] count;
    logic               ovf;

    int checks   = 0;
    int failures = 0;

    extremum_t   sb[$];
    bit          m_lv  = 1'b0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_lt  = '0;

    always #5 clk = ~clk;

    ei_min_store #(
        .DW         (16),
        .TW         (16),
        .DEPTH      (DEPTH),
        .MIN_GAP    (MIN_GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (clr),
        .i_trg      (trg),
        .i_time     (tim),
        .i_val      (val),
        .i_rd_ready (rd_ready),
        .o_rd_valid (rd_valid),
        .o_rd_time  (rd_time),
        .o_rd_val   (rd_val),
        .o_count    (count),
        .o_ovf      (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from its own state.
    task automatic step(input bit t_trg, input logic [15:0] t_time,
                        input logic signed [15:0] t_val, input bit t_rdy, input bit t_clr);
        extremum_t e;
        bit        pop;
        bit        full;
        bit        cand;
`ifdef MIN_SPACING_EN
        logic [15:0] d;
`endif
        trg      = t_trg;
        tim      = t_time;
        val      = t_val;
        rd_ready = t_rdy;
        clr      = t_clr;
        @(negedge clk);
        pop  = (sb.size() > 0) && t_rdy;
        full = (sb.size() == DEPTH);
        cand = t_trg && !t_clr && !(m_lv && (t_time == m_lt));
`ifdef MIN_SPACING_EN
        d = t_time - m_lt;
        if (m_lv && (d < 16'(MIN_GAP))) cand = 1'b0;
`endif
        check("rd_valid_pre", rd_valid, sb.size() > 0);
        if (t_clr) begin
            sb.delete();
            m_ovf = 1'b0;
            m_lv  = 1'b0;
        end else begin
            if (pop) begin
                e = sb.pop_front();
                check("pop_time", rd_time, e.tidx);
                check("pop_val", rd_val, e.val);
            end
            if (cand) begin
                if (!full || pop) begin
                    e.tidx = t_time;
                    e.val  = t_val;
                    sb.push_back(e);
                    m_lt = t_time;
                    m_lv = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        check("count", count, sb.size());
        check("rd_valid", rd_valid, sb.size() > 0);
        check("ovf", ovf, m_ovf);
        if (sb.size() > 0) begin
            check("head_time", rd_time, sb[0].tidx);
            check("head_val", rd_val, sb[0].val);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, rd_valid, 0);
        check({tag, "_time"}, rd_time, 0);
        check({tag, "_val"}, rd_val, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Single trigger appears one cycle later with value intact
        step(1'b1, 16'd3, -16'sd5, 1'b0, 1'b0);
        check("t1_time", rd_time, 3);
        check("t1_val", rd_val, -5);
        check("t1_count", count, 1);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Trigger held three cycles on the same time index
        repeat (3) step(1'b1, 16'd10, 16'sd7, 1'b0, 1'b0);
        check("t2_count", count, 1);
        check("t2_ovf", ovf, 0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Overfill, then flush
        for (int i = 0; i <= DEPTH; i++) step(1'b1, 16'(100 + i), 16'(i), 1'b0, 1'b0);
        check("t3_count", count, 16);
        check("t3_ovf", ovf, 1);
        check("t3_head", rd_time, 100);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        check("t3_clr_count", count, 0);
        check("t3_clr_valid", rd_valid, 0);
        check("t3_clr_ovf", ovf, 0);

        // Push while full with a simultaneous pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(200 + i), 16'(-i), 1'b0, 1'b0);
        step(1'b1, 16'd99, 16'sd42, 1'b1, 1'b0);
        check("t4_count", count, 16);
        check("t4_ovf", ovf, 0);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t4_tail", rd_time, 99);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset with entries held
        for (int i = 6; i <= 10; i++) step(1'b1, 16'(i), 16'(i), 1'b0, 1'b0);
        check("t5_pre_count", count, 5);
        trg = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t5_async");
        sb.delete();
        m_lv  = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 16'd10, 16'sd3, 1'b0, 1'b0);
        check("t5_count", count, 1);

        // Closely spaced minima
        step(1'b1, 16'd20, 16'sd1, 1'b0, 1'b0);
        step(1'b1, 16'd21, 16'sd2, 1'b0, 1'b0);
        step(1'b1, 16'd22, 16'sd3, 1'b0, 1'b0);
`ifdef MIN_SPACING_EN
        check("t6_count", count, 3);
`else
        check("t6_count", count, 4);
`endif

        // CLR wins over a same-cycle trigger; push into empty with ready high
        step(1'b1, 16'd500, 16'sd1, 1'b0, 1'b1);
        check("clr_trg_count", count, 0);
        step(1'b1, 16'd600, 16'sd2, 1'b1, 1'b0);
        check("empty_pushpop_count", count, 1);

        // Random traffic with frequent duplicates and occasional flushes
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom_range(0, 40)), 16'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 80) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
